// File: rtl/mem_port_arb.sv
// mem_port_arb
//   Shares the single core memory port between instruction fetch (I side) and load/store
//   (D side). At most one memory transaction is outstanding at a time. Each response is
//   routed back only to the side that issued the request.
//
//   A new request may issue in the same cycle that the outstanding response is accepted.
//   This creates an intentional combinational path from m_rsp_* to m_req_*. The block adds
//   no latency and does not buffer requests.
//
//   A request that is presented to memory but not yet accepted is locked to its side, so the
//   fields on m_req_* stay stable until the memory port takes them.
//
// Configuration macro
//   MEM_PORT_ARB_RR_EN  undefined: fixed priority, D side beats I side.
//                       defined:   round robin against the last granted side.
//
// Parameters
//   AW  address width
//   DW  data width (DW/8 byte strobes)
//
// Ports
//   clk, rst_n                          clock, asynchronous active-low reset
//   i_req_vld/rdy, i_req_pc             fetch request
//   i_rsp_vld/rdy, i_rsp_ir             fetch response
//   d_req_vld/rdy, d_req_addr/we/wdata/wstrb   load/store request
//   d_rsp_vld/rdy, d_rsp_rdata          load/store response
//   m_req_vld/rdy, m_req_addr/we/wdata/wstrb   memory request (muxed from the winner)
//   m_rsp_vld/rdy, m_rsp_rdata          memory response

module mem_port_arb #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req_vld,
    output logic              i_req_rdy,
    input  logic [AW-1:0]     i_req_pc,
    output logic              i_rsp_vld,
    input  logic              i_rsp_rdy,
    output logic [DW-1:0]     i_rsp_ir,

    input  logic              d_req_vld,
    output logic              d_req_rdy,
    input  logic [AW-1:0]     d_req_addr,
    input  logic              d_req_we,
    input  logic [DW-1:0]     d_req_wdata,
    input  logic [DW/8-1:0]   d_req_wstrb,
    output logic              d_rsp_vld,
    input  logic              d_rsp_rdy,
    output logic [DW-1:0]     d_rsp_rdata,

    output logic              m_req_vld,
    input  logic              m_req_rdy,
    output logic [AW-1:0]     m_req_addr,
    output logic              m_req_we,
    output logic [DW-1:0]     m_req_wdata,
    output logic [DW/8-1:0]   m_req_wstrb,
    input  logic              m_rsp_vld,
    output logic              m_rsp_rdy,
    input  logic [DW-1:0]     m_rsp_rdata
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    // Encoding of the owner, lock_owner and grant registers.
    localparam logic SideI = 1'b0;
    localparam logic SideD = 1'b1;

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   lock_q, lock_d;
    logic   lock_owner_q, lock_owner_d;

    logic   busy;
    logic   rsp_hs;
    logic   can_issue;
    logic   arb_win;
    logic   win;
    logic   win_vld;
    logic   req_hs;

`ifdef MEM_PORT_ARB_RR_EN
    logic   last_grant_q, last_grant_d;
`endif

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
`ifdef MEM_PORT_ARB_RR_EN
        if (i_req_vld && d_req_vld) begin
            arb_win = ~last_grant_q;
        end else begin
            arb_win = d_req_vld ? SideD : SideI;
        end
`else
        // D side wins any tie, so loads and stores never stall behind fetch.
        arb_win = d_req_vld ? SideD : SideI;
`endif
    end

    always_comb begin
        busy = (state_q == StBusy);

        // Only the owner's ready is forwarded. An unexpected response while idle is refused.
        m_rsp_rdy = busy && ((owner_q == SideD) ? d_rsp_rdy : i_rsp_rdy);
        rsp_hs    = busy && m_rsp_vld && m_rsp_rdy;
        can_issue = !busy || rsp_hs;

        // A presented but unaccepted request keeps its grant until memory takes it.
        win     = lock_q ? lock_owner_q : arb_win;
        win_vld = (win == SideD) ? d_req_vld : i_req_vld;

        m_req_vld = can_issue && win_vld;
        req_hs    = m_req_vld && m_req_rdy;

        i_req_rdy = req_hs && (win == SideI);
        d_req_rdy = req_hs && (win == SideD);

        if (win == SideD) begin
            m_req_addr  = d_req_addr;
            m_req_we    = d_req_we;
            m_req_wdata = d_req_wdata;
            m_req_wstrb = d_req_wstrb;
        end else begin
            m_req_addr  = i_req_pc;
            m_req_we    = 1'b0;
            m_req_wdata = '0;
            m_req_wstrb = '0;
        end
    end

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    always_comb begin
        i_rsp_vld   = busy && m_rsp_vld && (owner_q == SideI);
        d_rsp_vld   = busy && m_rsp_vld && (owner_q == SideD);
        i_rsp_ir    = m_rsp_rdata;
        d_rsp_rdata = m_rsp_rdata;
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;

        if (req_hs) begin
            // A new issue either starts a transaction or replaces the one that just responded.
            state_d = StBusy;
            owner_d = win;
            lock_d  = 1'b0;
        end else if (rsp_hs) begin
            state_d = StIdle;
        end

        if (m_req_vld && !m_req_rdy) begin
            lock_d       = 1'b1;
            lock_owner_d = win;
        end
    end

`ifdef MEM_PORT_ARB_RR_EN
    always_comb begin
        last_grant_d = req_hs ? win : last_grant_q;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            owner_q      <= SideI;
            lock_q       <= 1'b0;
            lock_owner_q <= SideI;
`ifdef MEM_PORT_ARB_RR_EN
            last_grant_q <= SideI;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
`ifdef MEM_PORT_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

`ifndef SYNTHESIS
    // Memory must not answer when nothing is outstanding.
    a_no_rsp_when_idle : assert property (
        @(posedge clk) disable iff (!rst_n) !((state_q == StIdle) && m_rsp_vld)
    ) else $error("mem_port_arb: m_rsp_vld while idle");
`endif

endmodule

// File: tb/tb_mem_port_arb.sv
`timescale 1ns/1ps
module tb_mem_port_arb;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

`ifdef MEM_PORT_ARB_RR_EN
    localparam bit RrMode = 1'b1;
`else
    localparam bit RrMode = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic i_req_vld, i_req_rdy, i_rsp_vld, i_rsp_rdy;
    logic [AW-1:0] i_req_pc;
    logic [DW-1:0] i_rsp_ir;
    logic d_req_vld, d_req_rdy, d_req_we, d_rsp_vld, d_rsp_rdy;
    logic [AW-1:0] d_req_addr;
    logic [DW-1:0] d_req_wdata, d_rsp_rdata;
    logic [DW/8-1:0] d_req_wstrb;
    logic m_req_vld, m_req_rdy, m_req_we, m_rsp_vld, m_rsp_rdy;
    logic [AW-1:0] m_req_addr;
    logic [DW-1:0] m_req_wdata, m_rsp_rdata;
    logic [DW/8-1:0] m_req_wstrb;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arb #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_vld(i_req_vld), .i_req_rdy(i_req_rdy), .i_req_pc(i_req_pc),
        .i_rsp_vld(i_rsp_vld), .i_rsp_rdy(i_rsp_rdy), .i_rsp_ir(i_rsp_ir),
        .d_req_vld(d_req_vld), .d_req_rdy(d_req_rdy), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
        .d_rsp_vld(d_rsp_vld), .d_rsp_rdy(d_rsp_rdy), .d_rsp_rdata(d_rsp_rdata),
        .m_req_vld(m_req_vld), .m_req_rdy(m_req_rdy), .m_req_addr(m_req_addr),
        .m_req_we(m_req_we), .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
        .m_rsp_vld(m_rsp_vld), .m_rsp_rdy(m_rsp_rdy), .m_rsp_rdata(m_rsp_rdata)
    );

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_req_vld = 0; i_req_pc = '0; i_rsp_rdy = 0;
        d_req_vld = 0; d_req_addr = '0; d_req_we = 0; d_req_wdata = '0; d_req_wstrb = '0;
        d_rsp_rdy = 0; m_req_rdy = 0; m_rsp_vld = 0; m_rsp_rdata = '0;
    endtask

    task automatic pulse_reset();
        clear_inputs();
        rst_n = 0;
        adv();
        adv();
        rst_n = 1;
        adv();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        settle();
        checks++;
        if ({i_req_rdy, d_req_rdy, i_rsp_vld, d_rsp_vld, m_rsp_rdy, m_req_vld} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=000000",
                     {i_req_rdy, d_req_rdy, i_rsp_vld, d_rsp_vld, m_rsp_rdy, m_req_vld});
        end
        i_req_vld = 1; i_req_pc = 32'h0000_1000;
        #1;
        checks++;
        if ({m_req_vld, i_req_rdy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_req_vld got=%b exp=10", {m_req_vld, i_req_rdy});
        end
        checks++;
        if (m_req_addr !== 32'h0000_1000) begin
            errors++;
            $display("FAIL reset_req_addr got=%h exp=00001000", m_req_addr);
        end
        i_req_vld = 0;
        adv();
        rst_n = 1;
        adv();
    endtask

    task automatic test_i_only();
        logic [31:0] pc, rd;
        pc = $urandom; rd = $urandom;
        clear_inputs();
        i_req_vld = 1; i_req_pc = pc; m_req_rdy = 1; i_rsp_rdy = 1;
        settle();
        checks++;
        if ({i_req_rdy, d_req_rdy, m_req_vld, m_req_we} !== 4'b1010) begin
            errors++;
            $display("FAIL i_only_issue got=%b exp=1010", {i_req_rdy, d_req_rdy, m_req_vld, m_req_we});
        end
        checks++;
        if ({m_req_addr, m_req_wdata, m_req_wstrb} !== {pc, 32'h0, 4'h0}) begin
            errors++;
            $display("FAIL i_only_fields got=%h/%h/%h exp=%h/0/0", m_req_addr, m_req_wdata,
                     m_req_wstrb, pc);
        end
        adv();
        i_req_vld = 0; m_rsp_vld = 1; m_rsp_rdata = rd;
        settle();
        checks++;
        if ({i_rsp_vld, d_rsp_vld, m_rsp_rdy, m_req_vld} !== 4'b1010) begin
            errors++;
            $display("FAIL i_only_rsp got=%b exp=1010", {i_rsp_vld, d_rsp_vld, m_rsp_rdy, m_req_vld});
        end
        checks++;
        if (i_rsp_ir !== rd) begin
            errors++;
            $display("FAIL i_only_ir got=%h exp=%h", i_rsp_ir, rd);
        end
        adv();
        m_rsp_vld = 0;
        settle();
        checks++;
        if ({i_rsp_vld, m_rsp_rdy} !== 2'b00) begin
            errors++;
            $display("FAIL i_only_idle got=%b exp=00", {i_rsp_vld, m_rsp_rdy});
        end
        adv();
        clear_inputs();
    endtask

    task automatic test_fixed_prio();
        logic [31:0] pc, da, wd, rd1, rd2;
        pc = $urandom; da = $urandom; wd = $urandom; rd1 = $urandom; rd2 = $urandom;
        clear_inputs();
        i_req_vld = 1; i_req_pc = pc;
        d_req_vld = 1; d_req_addr = da; d_req_we = 1; d_req_wdata = wd; d_req_wstrb = 4'hF;
        m_req_rdy = 1; d_rsp_rdy = 1; i_rsp_rdy = 1;
        settle();
        checks++;
        if ({d_req_rdy, i_req_rdy, m_req_vld, m_req_we} !== 4'b1011) begin
            errors++;
            $display("FAIL prio_d_grant got=%b exp=1011", {d_req_rdy, i_req_rdy, m_req_vld, m_req_we});
        end
        checks++;
        if ({m_req_addr, m_req_wdata, m_req_wstrb} !== {da, wd, 4'hF}) begin
            errors++;
            $display("FAIL prio_d_fields got=%h/%h/%h exp=%h/%h/f", m_req_addr, m_req_wdata,
                     m_req_wstrb, da, wd);
        end
        adv();
        d_req_vld = 0; m_rsp_vld = 1; m_rsp_rdata = rd1;
        settle();
        checks++;
        if ({d_rsp_vld, i_rsp_vld, m_rsp_rdy, i_req_rdy, m_req_vld, m_req_we} !== 6'b101110) begin
            errors++;
            $display("FAIL prio_d_rsp_i_issue got=%b exp=101110",
                     {d_rsp_vld, i_rsp_vld, m_rsp_rdy, i_req_rdy, m_req_vld, m_req_we});
        end
        checks++;
        if ({m_req_addr, d_rsp_rdata} !== {pc, rd1}) begin
            errors++;
            $display("FAIL prio_i_addr_rdata got=%h/%h exp=%h/%h", m_req_addr, d_rsp_rdata, pc, rd1);
        end
        adv();
        i_req_vld = 0; m_rsp_rdata = rd2;
        settle();
        checks++;
        if ({i_rsp_vld, d_rsp_vld, i_rsp_ir} !== {2'b10, rd2}) begin
            errors++;
            $display("FAIL prio_i_rsp got=%b/%h exp=10/%h", {i_rsp_vld, d_rsp_vld}, i_rsp_ir, rd2);
        end
        adv();
        clear_inputs();
    endtask

    task automatic test_lock();
        logic [31:0] pc, pc2, da;
        pc = $urandom; pc2 = $urandom; da = $urandom;
        clear_inputs();
        i_rsp_rdy = 1; d_rsp_rdy = 1;
        // I presented but stalled; D arriving later must not steal the grant.
        i_req_vld = 1; i_req_pc = pc;
        settle();
        adv();
        d_req_vld = 1; d_req_addr = da;
        settle();
        checks++;
        if ({m_req_vld, i_req_rdy, d_req_rdy, m_req_addr} !== {3'b100, pc}) begin
            errors++;
            $display("FAIL lock_i_hold got=%b/%h exp=100/%h", {m_req_vld, i_req_rdy, d_req_rdy},
                     m_req_addr, pc);
        end
        adv();
        m_req_rdy = 1;
        settle();
        checks++;
        if ({i_req_rdy, d_req_rdy, m_req_addr} !== {2'b10, pc}) begin
            errors++;
            $display("FAIL lock_i_accept got=%b/%h exp=10/%h", {i_req_rdy, d_req_rdy}, m_req_addr, pc);
        end
        adv();
        // Response cycle: D wins but memory stalls it.
        i_req_pc = pc2; m_req_rdy = 0; m_rsp_vld = 1;
        settle();
        checks++;
        if ({i_rsp_vld, m_req_vld, d_req_rdy, m_req_addr} !== {3'b110, da}) begin
            errors++;
            $display("FAIL lock_d_present got=%b/%h exp=110/%h", {i_rsp_vld, m_req_vld, d_req_rdy},
                     m_req_addr, da);
        end
        adv();
        m_rsp_vld = 0;
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++;
            if ({m_req_vld, i_req_rdy, d_req_rdy, m_req_addr} !== {3'b100, da}) begin
                errors++;
                $display("FAIL lock_d_stall%0d got=%b/%h exp=100/%h", k,
                         {m_req_vld, i_req_rdy, d_req_rdy}, m_req_addr, da);
            end
            adv();
        end
        m_req_rdy = 1;
        settle();
        checks++;
        if ({d_req_rdy, i_req_rdy, m_req_addr} !== {2'b10, da}) begin
            errors++;
            $display("FAIL lock_d_accept got=%b/%h exp=10/%h", {d_req_rdy, i_req_rdy}, m_req_addr, da);
        end
        adv();
        d_req_vld = 0; m_rsp_vld = 1;
        settle();
        checks++;
        if ({d_rsp_vld, i_req_rdy, m_req_addr} !== {2'b11, pc2}) begin
            errors++;
            $display("FAIL lock_i_after got=%b/%h exp=11/%h", {d_rsp_vld, i_req_rdy}, m_req_addr, pc2);
        end
        adv();
        i_req_vld = 0;
        settle();
        checks++;
        if ({i_rsp_vld, d_rsp_vld} !== 2'b10) begin
            errors++;
            $display("FAIL lock_i_rsp got=%b exp=10", {i_rsp_vld, d_rsp_vld});
        end
        adv();
        clear_inputs();
    endtask

    task automatic test_rr();
        logic [31:0] ia, da;
        bit exp_d, prev_d;
        pulse_reset();
        ia = 32'h100; da = 32'h200; prev_d = 0;
        i_req_vld = 1; d_req_vld = 1; m_req_rdy = 1; i_rsp_rdy = 1; d_rsp_rdy = 1;
        for (int n = 0; n < 8; n++) begin
            i_req_pc = ia; d_req_addr = da;
            m_rsp_vld = (n != 0);
            exp_d = RrMode ? ((n % 2) == 0) : 1'b1;
            settle();
            checks++;
            if ({d_req_rdy, i_req_rdy, m_req_addr} !== {exp_d, !exp_d, (exp_d ? da : ia)}) begin
                errors++;
                $display("FAIL rr_grant%0d got=%b/%h exp=%b/%h", n, {d_req_rdy, i_req_rdy},
                         m_req_addr, {exp_d, !exp_d}, (exp_d ? da : ia));
            end
            if (n != 0) begin
                checks++;
                if ({d_rsp_vld, i_rsp_vld} !== {prev_d, !prev_d}) begin
                    errors++;
                    $display("FAIL rr_rsp%0d got=%b exp=%b", n, {d_rsp_vld, i_rsp_vld},
                             {prev_d, !prev_d});
                end
            end
            adv();
            if (exp_d) da++; else ia++;
            prev_d = exp_d;
        end
        i_req_vld = 0; d_req_vld = 0; m_rsp_vld = 1;
        settle();
        checks++;
        if ({d_rsp_vld, i_rsp_vld, m_req_vld} !== {prev_d, !prev_d, 1'b0}) begin
            errors++;
            $display("FAIL rr_last_rsp got=%b exp=%b", {d_rsp_vld, i_rsp_vld, m_req_vld},
                     {prev_d, !prev_d, 1'b0});
        end
        adv();
        clear_inputs();
    endtask

    task automatic test_rsp_stall();
        logic [31:0] da, pc, rd;
        da = $urandom; pc = $urandom; rd = $urandom;
        clear_inputs();
        d_req_vld = 1; d_req_addr = da; m_req_rdy = 1;
        settle();
        adv();
        d_req_vld = 0; i_req_vld = 1; i_req_pc = pc; i_rsp_rdy = 1;
        m_rsp_vld = 1; m_rsp_rdata = rd; d_rsp_rdy = 0;
        for (int k = 0; k < 2; k++) begin
            settle();
            checks++;
            if ({d_rsp_vld, i_rsp_vld, m_rsp_rdy, m_req_vld, i_req_rdy} !== 5'b10000) begin
                errors++;
                $display("FAIL stall_cyc%0d got=%b exp=10000", k,
                         {d_rsp_vld, i_rsp_vld, m_rsp_rdy, m_req_vld, i_req_rdy});
            end
            adv();
        end
        d_rsp_rdy = 1;
        settle();
        checks++;
        if ({d_rsp_vld, m_rsp_rdy, i_req_rdy, m_req_vld, d_rsp_rdata} !== {4'b1111, rd}) begin
            errors++;
            $display("FAIL stall_release got=%b/%h exp=1111/%h",
                     {d_rsp_vld, m_rsp_rdy, i_req_rdy, m_req_vld}, d_rsp_rdata, rd);
        end
        adv();
        i_req_vld = 0;
        settle();
        checks++;
        if ({i_rsp_vld, d_rsp_vld} !== 2'b10) begin
            errors++;
            $display("FAIL stall_i_rsp got=%b exp=10", {i_rsp_vld, d_rsp_vld});
        end
        adv();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        logic [31:0] pc, rd;
        pc = $urandom; rd = $urandom;
        clear_inputs();
        d_req_vld = 1; d_req_we = 1; d_req_wstrb = 4'h3; m_req_rdy = 1;
        settle();
        adv();
        clear_inputs();
        #2 rst_n = 0;
        m_rsp_vld = 1; d_rsp_rdy = 1; i_rsp_rdy = 1;
        settle();
        checks++;
        if ({d_rsp_vld, i_rsp_vld, m_rsp_rdy} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_rsp got=%b exp=000", {d_rsp_vld, i_rsp_vld, m_rsp_rdy});
        end
        adv();
        m_rsp_vld = 0; rst_n = 1;
        i_req_vld = 1; i_req_pc = pc; m_req_rdy = 1;
        settle();
        checks++;
        if ({i_req_rdy, m_req_vld, m_req_addr} !== {2'b11, pc}) begin
            errors++;
            $display("FAIL rst_mid_issue got=%b/%h exp=11/%h", {i_req_rdy, m_req_vld}, m_req_addr, pc);
        end
        adv();
        i_req_vld = 0; m_rsp_vld = 1; m_rsp_rdata = rd;
        settle();
        checks++;
        if ({i_rsp_vld, d_rsp_vld, i_rsp_ir} !== {2'b10, rd}) begin
            errors++;
            $display("FAIL rst_mid_rsp2 got=%b/%h exp=10/%h", {i_rsp_vld, d_rsp_vld}, i_rsp_ir, rd);
        end
        adv();
        clear_inputs();
    endtask

    // Transaction-level reference: one outstanding slot, a held grant for stalled requests.
    task automatic test_random();
        bit ipend, dpend, out_busy, out_d, held, held_d, last_d, mrsp;
        bit rsp_take, free, w_d, ev, acc;
        logic [31:0] ipc, daddr, dwdata, rdata;
        logic [3:0] dwstrb;
        bit dwe;
        pulse_reset();
        ipend = 0; dpend = 0; out_busy = 0; out_d = 0; held = 0; held_d = 0; last_d = 0;
        mrsp = 0; ipc = '0; daddr = '0; dwdata = '0; dwstrb = '0; dwe = 0; rdata = '0;
        for (int n = 0; n < 400; n++) begin
            if (!ipend && ($urandom_range(2) == 0)) begin ipend = 1; ipc = $urandom; end
            if (!dpend && ($urandom_range(2) == 0)) begin
                dpend = 1; daddr = $urandom; dwe = $urandom_range(1);
                dwdata = $urandom; dwstrb = $urandom_range(15);
            end
            if (out_busy && !mrsp && ($urandom_range(1) == 1)) begin mrsp = 1; rdata = $urandom; end
            i_req_vld = ipend; i_req_pc = ipc;
            d_req_vld = dpend; d_req_addr = daddr; d_req_we = dwe;
            d_req_wdata = dwdata; d_req_wstrb = dwstrb;
            m_rsp_vld = mrsp; m_rsp_rdata = rdata;
            m_req_rdy = ($urandom_range(2) != 0);
            i_rsp_rdy = ($urandom_range(2) != 0);
            d_rsp_rdy = ($urandom_range(2) != 0);

            rsp_take = out_busy && mrsp && (out_d ? d_rsp_rdy : i_rsp_rdy);
            free = !out_busy || rsp_take;
            if (held) w_d = held_d;
            else if (ipend && dpend) w_d = RrMode ? !last_d : 1'b1;
            else w_d = dpend;
            ev = free && (w_d ? dpend : ipend);
            acc = ev && m_req_rdy;

            settle();
            checks++;
            if ({m_req_vld, i_req_rdy, d_req_rdy} !== {ev, acc && !w_d, acc && w_d}) begin
                errors++;
                $display("FAIL rand_req%0d got=%b exp=%b", n, {m_req_vld, i_req_rdy, d_req_rdy},
                         {ev, acc && !w_d, acc && w_d});
            end
            if (ev) begin
                checks++;
                if ({m_req_addr, m_req_we, m_req_wdata, m_req_wstrb} !==
                    (w_d ? {daddr, dwe, dwdata, dwstrb} : {ipc, 1'b0, 32'h0, 4'h0})) begin
                    errors++;
                    $display("FAIL rand_fields%0d got=%h/%b/%h/%h", n, m_req_addr, m_req_we,
                             m_req_wdata, m_req_wstrb);
                end
            end
            checks++;
            if ({i_rsp_vld, d_rsp_vld, m_rsp_rdy} !== {out_busy && mrsp && !out_d,
                out_busy && mrsp && out_d, out_busy && (out_d ? d_rsp_rdy : i_rsp_rdy)}) begin
                errors++;
                $display("FAIL rand_rsp%0d got=%b exp=%b", n, {i_rsp_vld, d_rsp_vld, m_rsp_rdy},
                         {out_busy && mrsp && !out_d, out_busy && mrsp && out_d,
                          out_busy && (out_d ? d_rsp_rdy : i_rsp_rdy)});
            end
            if (mrsp) begin
                checks++;
                if ({i_rsp_ir, d_rsp_rdata} !== {rdata, rdata}) begin
                    errors++;
                    $display("FAIL rand_rdata%0d got=%h/%h exp=%h", n, i_rsp_ir, d_rsp_rdata, rdata);
                end
            end

            if (rsp_take) begin mrsp = 0; out_busy = 0; end
            if (acc) begin
                out_busy = 1; out_d = w_d; last_d = w_d; held = 0;
                if (w_d) dpend = 0; else ipend = 0;
            end else if (ev) begin
                held = 1; held_d = w_d;
            end
            adv();
        end
        clear_inputs();
        rst_n = 0;
        adv();
        rst_n = 1;
        adv();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        clear_inputs();
        test_reset();
        test_i_only();
        test_fixed_prio();
        test_lock();
        test_rr();
        test_rsp_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
